kbd: RTL and testbench

Character input device: the read-side counterpart of the character display. A host-side source (testbench or external key driver) pushes ASCII bytes through a valid/ready handshake into a small FIFO, and the CPU polls `flag` and pops bytes with a read strobe. Intake is paced by a fixed inter-character gap, so the CPU sees a slow device. It sits on the CPU's I/O bus next to the display device.

---
 rtl/kbd_pkg.sv | 10 +
 rtl/kbd_if.sv | 22 ++
 rtl/kbd_char_fifo.sv | 50 +++++
 rtl/kbd.sv | 39 +++
 tb/tb_kbd.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard input device: bus widths and the
// default FIFO depth and intake gap.
package kbd_pkg;
   localparam int DATA_W    = 32;
   localparam int CHAR_W    = DATA_W / 4;
   localparam int KBD_DEPTH = 4;
   localparam int KBD_GAP   = 7;

   typedef logic [CHAR_W-1:0] char_t;
endpackage

// File: rtl/kbd_if.sv
// Key-source handshake and CPU polling bus of the keyboard device.
interface kbd_if import kbd_pkg::*; #(
   parameter int DEPTH = KBD_DEPTH
);
   char_t                  key_data;
   logic                   key_valid;
   logic                   key_ready;
   logic                   re;
   char_t                  dout;
   logic                   flag;
   logic [$clog2(DEPTH):0] level;

   modport master (
      output key_data, key_valid, re,
      input  key_ready, dout, flag, level
   );

   modport slave (
      input  key_data, key_valid, re,
      output key_ready, dout, flag, level
   );
endinterface

// File: rtl/kbd_char_fifo.sv
// First-word-fall-through FIFO for characters; push and pop are ignored
// when full or empty respectively, and both are suppressed during reset.
module char_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic          do_push, do_pop;

   assign do_push = push & ~full & ~rst;
   assign do_pop  = pop & ~empty & ~rst;
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign dout    = mem[rp];

   always_ff @(posedge clk) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end
endmodule

// File: rtl/kbd.sv
// Keyboard input device: paces key intake with a fixed idle gap after each
// accepted character and buffers bytes for the CPU to poll and pop.
module kbd import kbd_pkg::*; #(
   parameter int DEPTH = KBD_DEPTH,
   parameter int GAP   = KBD_GAP
) (
   input  logic clk,
   input  logic rst,
   kbd_if.slave bus
);
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

   logic [GW-1:0] gap_cnt;
   logic          full, empty, push, pop;

   // Ready comes from registers only, never from key_valid.
   assign bus.key_ready = ~full & (gap_cnt == '0);
   assign push          = bus.key_valid & bus.key_ready;
   assign pop           = bus.re & ~empty;
   assign bus.flag      = ~empty;

   always_ff @(posedge clk) begin
      if (rst)                  gap_cnt <= '0;
      else if (push)            gap_cnt <= GW'(GAP);
      else if (gap_cnt != '0)   gap_cnt <= gap_cnt - 1'b1;
   end

   char_fifo #(.DEPTH(DEPTH), .W(CHAR_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (bus.key_data),
      .dout  (bus.dout),
      .full  (full),
      .empty (empty),
      .count (bus.level)
   );
endmodule

// File: tb/tb_kbd.sv
// Directed and randomized checks of kbd against a queue/timestamp model,
// on one default instance (GAP=7) and one back-to-back instance (GAP=0).
module tb_kbd;
   import kbd_pkg::*;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   always #5 clk = ~clk;

   kbd_if #(.DEPTH(4)) a_if ();
   kbd_if #(.DEPTH(4)) b_if ();

   kbd #(.DEPTH(4), .GAP(7)) dut_a (.clk(clk), .rst(rst_a), .bus(a_if.slave));
   kbd #(.DEPTH(4), .GAP(0)) dut_b (.clk(clk), .rst(rst_b), .bus(b_if.slave));

   int tests = 0;
   int fails = 0;
   int now = 0;
   int last_acc = -1000;
   int m_gap = 7;
   int m_depth = 4;
   int sel = 0;
   logic [7:0] mq[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle on the selected instance, then compare it to the model.
   task automatic cyc(input logic kv, input logic [7:0] kd, input logic r,
                      input logic rs, output logic acc);
      logic m_rdy;
      logic [7:0] o_dout;
      logic o_rdy, o_flag;
      logic [2:0] o_lvl;
      m_rdy = (mq.size() < m_depth) && (now - last_acc > m_gap);
      if (sel == 0) begin
         a_if.key_valid = kv; a_if.key_data = kd; a_if.re = r; rst_a = rs;
         acc = a_if.key_ready & kv & ~rs;
      end else begin
         b_if.key_valid = kv; b_if.key_data = kd; b_if.re = r; rst_b = rs;
         acc = b_if.key_ready & kv & ~rs;
      end
      chk("accept", acc, kv && m_rdy && !rs);
      @(posedge clk); #1;
      if (rs) begin
         mq.delete();
         last_acc = -1000;
      end else begin
         if (r && mq.size() > 0) void'(mq.pop_front());
         if (kv && m_rdy) begin
            mq.push_back(kd);
            last_acc = now;
         end
      end
      now++;
      if (sel == 0) begin
         o_rdy = a_if.key_ready; o_flag = a_if.flag; o_lvl = a_if.level; o_dout = a_if.dout;
      end else begin
         o_rdy = b_if.key_ready; o_flag = b_if.flag; o_lvl = b_if.level; o_dout = b_if.dout;
      end
      chk("key_ready", o_rdy, (mq.size() < m_depth) && (now - last_acc > m_gap));
      chk("flag", o_flag, mq.size() != 0);
      chk("level", o_lvl, mq.size());
      if (mq.size() != 0) chk("dout", o_dout, mq[0]);
   endtask

   task automatic push_wait(input logic [7:0] d);
      logic acc = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, d, 1'b0, 1'b0, acc);
         if (acc) break;
      end
      chk("push_wait", acc, 1);
   endtask

   task automatic wait_ready();
      logic acc;
      for (int i = 0; i < 20; i++) begin
         if (a_if.key_ready) break;
         cyc(1'b0, 8'h00, 1'b0, 1'b0, acc);
      end
      chk("wait_ready", a_if.key_ready, 1);
   endtask

   task automatic drain();
      logic acc;
      for (int i = 0; i < 8; i++) begin
         if (!a_if.flag) break;
         cyc(1'b0, 8'h00, 1'b1, 1'b0, acc);
      end
      chk("drain", a_if.flag, 0);
   endtask

   initial begin
      logic acc;
      logic pv;
      logic r, rs;
      logic [7:0] pend;
      int n, k;
      int tacc[3];

      a_if.key_valid = 0; a_if.key_data = 0; a_if.re = 0;
      b_if.key_valid = 0; b_if.key_data = 0; b_if.re = 0;
      rst_a = 1; rst_b = 1;

      // Reset state
      cyc(1'b0, 8'h00, 1'b0, 1'b1, acc);
      chk("rst_flag", a_if.flag, 0);
      chk("rst_level", a_if.level, 0);
      chk("rst_ready", a_if.key_ready, 1);

      // Single byte and its gap
      cyc(1'b1, 8'h41, 1'b0, 1'b0, acc);
      chk("t1_acc", acc, 1);
      chk("t1_flag", a_if.flag, 1);
      chk("t1_dout", a_if.dout, 8'h41);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         if (a_if.key_ready) break;
         n++;
         cyc(1'b0, 8'h00, 1'b0, 1'b0, acc);
      end
      chk("t1_gap_len", n, 7);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, acc);
      chk("t1_pop_flag", a_if.flag, 0);

      // Pacing and order with key_valid held
      k = 0;
      for (int i = 0; i < 40 && k < 3; i++) begin
         cyc(1'b1, 8'(8'h31 + k), 1'b0, 1'b0, acc);
         if (acc) begin
            tacc[k] = now - 1;
            k++;
         end
      end
      chk("t2_accepts", k, 3);
      chk("t2_space1", tacc[1] - tacc[0], 8);
      chk("t2_space2", tacc[2] - tacc[1], 8);
      for (int j = 0; j < 3; j++) begin
         chk("t2_order", a_if.dout, 8'(8'h31 + j));
         cyc(1'b0, 8'h00, 1'b1, 1'b0, acc);
      end
      chk("t2_empty", a_if.flag, 0);

      // Full FIFO blocks intake until a pop frees a slot
      for (int i = 0; i < 4; i++) push_wait(8'(8'h30 + i));
      repeat (10) cyc(1'b0, 8'h00, 1'b0, 1'b0, acc);
      chk("t3_level_full", a_if.level, 4);
      chk("t3_ready_full", a_if.key_ready, 0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, acc);
      chk("t3_level_pop", a_if.level, 3);
      chk("t3_ready_pop", a_if.key_ready, 1);
      cyc(1'b1, 8'h34, 1'b0, 1'b0, acc);
      chk("t3_fifth_acc", acc, 1);
      drain();

      // Simultaneous push and pop
      push_wait(8'h50);
      push_wait(8'h51);
      wait_ready();
      cyc(1'b1, 8'h5A, 1'b1, 1'b0, acc);
      chk("t5_acc_l2", acc, 1);
      chk("t5_level_l2", a_if.level, 2);
      chk("t5_dout_l2", a_if.dout, 8'h51);
      drain();
      wait_ready();
      cyc(1'b1, 8'h5A, 1'b1, 1'b0, acc);
      chk("t5_level_l0", a_if.level, 1);
      chk("t5_dout_l0", a_if.dout, 8'h5A);
      drain();
      cyc(1'b0, 8'h00, 1'b1, 1'b0, acc);
      chk("t5_re_empty_level", a_if.level, 0);
      chk("t5_re_empty_flag", a_if.flag, 0);

      // Reset mid-operation with a pending gap and key_valid high
      push_wait(8'h60);
      push_wait(8'h61);
      push_wait(8'h62);
      chk("t6_level3", a_if.level, 3);
      chk("t6_gap_pending", a_if.key_ready, 0);
      cyc(1'b1, 8'h77, 1'b0, 1'b1, acc);
      chk("t6_flag", a_if.flag, 0);
      chk("t6_level", a_if.level, 0);
      chk("t6_ready", a_if.key_ready, 1);

      // Randomized traffic on the paced instance
      pv = 0; pend = 8'h00;
      for (int i = 0; i < 400; i++) begin
         if (!pv && ($urandom % 2 == 0)) begin
            pend = 8'($urandom);
            pv = 1;
         end
         r  = ($urandom % 3 == 0);
         rs = ($urandom % 97 == 0);
         cyc(pv, pend, r, rs, acc);
         if (acc || rs) pv = 0;
      end

      // Switch to the back-to-back instance
      a_if.key_valid = 0; a_if.re = 0; rst_a = 0;
      sel = 1; m_gap = 0; mq.delete(); last_acc = -1000;
      cyc(1'b0, 8'h00, 1'b0, 1'b1, acc);
      chk("b_rst_ready", b_if.key_ready, 1);

      // Wrap-around: pointers lap the 4-entry store twice
      cyc(1'b1, 8'h41, 1'b0, 1'b0, acc);
      for (int i = 1; i < 10; i++) begin
         chk("t4_wrap_dout", b_if.dout, 8'(8'h41 + i - 1));
         cyc(1'b1, 8'(8'h41 + i), 1'b1, 1'b0, acc);
         chk("t4_wrap_acc", acc, 1);
      end
      chk("t4_last", b_if.dout, 8'h4A);
      chk("t4_level", b_if.level, 1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, acc);
      chk("t4_empty", b_if.flag, 0);

      pv = 0;
      for (int i = 0; i < 300; i++) begin
         if (!pv && ($urandom % 4 != 0)) begin
            pend = 8'($urandom);
            pv = 1;
         end
         r  = ($urandom % 2 == 0);
         rs = ($urandom % 101 == 0);
         cyc(pv, pend, r, rs, acc);
         if (acc || rs) pv = 0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
